// File: rtl/aud_ctrl_sched.sv
// rtl/aud_ctrl_sched.sv - audio record/playback sequencer and SRAM arbiter
//
// Turns debounced key pulses into one-cycle start/pause/stop commands for the
// recorder and the playback DSP, latches a sanitised speed/mode on entry to
// PLAY, remembers the length of the last recording, ends playback at that
// length, and shares the single SRAM port between recorder and DSP.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_key_*                 one-cycle key pulses (stop > pause > rec > play)
//   i_cfg_speed/mode        playback configuration, sampled on entry to PLAY
//   i_rec_addr/data/we      recorder write side
//   i_dsp_addr/finished     DSP read side and end-of-memory flag
//   o_rec_*, o_dsp_*        registered one-cycle command pulses
//   o_speed, o_fast,
//   o_slow_0, o_slow_1      latched configuration (mode is one-hot)
//   o_sram_*                muxed SRAM port (we_n active low)
//   o_rec_len               length of the last completed recording
//   o_state                 FSM state code for display
module aud_ctrl_sched #(
  parameter int ADDR_W    = 20,
  parameter int SPEED_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  input  logic [3:0]        i_cfg_speed,
  input  logic [1:0]        i_cfg_mode,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [15:0]       i_rec_data,
  input  logic              i_rec_we,
  input  logic [ADDR_W-1:0] i_dsp_addr,
  input  logic              i_dsp_finished,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_dsp_start,
  output logic              o_dsp_pause,
  output logic              o_dsp_stop,
  output logic [3:0]        o_speed,
  output logic              o_fast,
  output logic              o_slow_0,
  output logic              o_slow_1,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [15:0]       o_sram_wdata,
  output logic              o_sram_we_n,
  output logic [ADDR_W-1:0] o_rec_len,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REC        = 3'd1,
    ST_REC_PAUSE  = 3'd2,
    ST_PLAY       = 3'd3,
    ST_PLAY_PAUSE = 3'd4
  } state_t;

  localparam logic [3:0] SPEED_LIM = 4'(SPEED_MAX);

  state_t state, state_nxt;

  logic rec_start_nxt, rec_pause_nxt, rec_stop_nxt;
  logic dsp_start_nxt, dsp_pause_nxt, dsp_stop_nxt;
  logic len_load, cfg_load;

  // Only the highest-priority key survives; lower ones are dropped even
  // when the winner has no meaning in the current state.
  logic k_stop, k_pause, k_rec, k_play;
  assign k_stop  = i_key_stop;
  assign k_pause = ~i_key_stop & i_key_pause;
  assign k_rec   = ~i_key_stop & ~i_key_pause & i_key_rec;
  assign k_play  = ~i_key_stop & ~i_key_pause & ~i_key_rec & i_key_play;

  logic rec_full, play_end;
  assign rec_full = &i_rec_addr;
  assign play_end = i_dsp_finished | (i_dsp_addr >= o_rec_len);

  logic [3:0] speed_san;
  logic [2:0] mode_oh;  // {fast, slow_0, slow_1}

  always_comb begin
    speed_san = i_cfg_speed;
    if (i_cfg_speed == 4'd0)
      speed_san = 4'd1;
    else if (i_cfg_speed > SPEED_LIM)
      speed_san = SPEED_LIM;
  end

  always_comb begin
    mode_oh = 3'b100;
    case (i_cfg_mode)
      2'd1:    mode_oh = 3'b010;
      2'd2:    mode_oh = 3'b001;
      default: mode_oh = 3'b100;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    rec_start_nxt = 1'b0;
    rec_pause_nxt = 1'b0;
    rec_stop_nxt  = 1'b0;
    dsp_start_nxt = 1'b0;
    dsp_pause_nxt = 1'b0;
    dsp_stop_nxt  = 1'b0;
    len_load      = 1'b0;
    cfg_load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (k_rec) begin
          state_nxt     = ST_REC;
          rec_start_nxt = 1'b1;
        end else if (k_play && o_rec_len != '0) begin
          state_nxt     = ST_PLAY;
          dsp_start_nxt = 1'b1;
          cfg_load      = 1'b1;
        end
      end
      ST_REC: begin
        // Memory-full auto-stop wins over pause; a simultaneous stop key
        // still yields only one stop pulse.
        if (k_stop || rec_full) begin
          state_nxt    = ST_IDLE;
          rec_stop_nxt = 1'b1;
          len_load     = 1'b1;
        end else if (k_pause) begin
          state_nxt     = ST_REC_PAUSE;
          rec_pause_nxt = 1'b1;
        end
      end
      ST_REC_PAUSE: begin
        if (k_stop) begin
          state_nxt    = ST_IDLE;
          rec_stop_nxt = 1'b1;
          len_load     = 1'b1;
        end else if (k_pause) begin
          state_nxt     = ST_REC;
          rec_pause_nxt = 1'b1;
        end
      end
      ST_PLAY: begin
        if (k_stop || play_end) begin
          state_nxt    = ST_IDLE;
          dsp_stop_nxt = 1'b1;
        end else if (k_pause) begin
          state_nxt     = ST_PLAY_PAUSE;
          dsp_pause_nxt = 1'b1;
        end
      end
      ST_PLAY_PAUSE: begin
        if (k_stop) begin
          state_nxt    = ST_IDLE;
          dsp_stop_nxt = 1'b1;
        end else if (k_pause) begin
          state_nxt     = ST_PLAY;
          dsp_pause_nxt = 1'b1;
          cfg_load      = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      o_rec_start <= 1'b0;
      o_rec_pause <= 1'b0;
      o_rec_stop  <= 1'b0;
      o_dsp_start <= 1'b0;
      o_dsp_pause <= 1'b0;
      o_dsp_stop  <= 1'b0;
      o_speed     <= 4'd1;
      o_fast      <= 1'b1;
      o_slow_0    <= 1'b0;
      o_slow_1    <= 1'b0;
      o_rec_len   <= '0;
    end else begin
      state       <= state_nxt;
      o_rec_start <= rec_start_nxt;
      o_rec_pause <= rec_pause_nxt;
      o_rec_stop  <= rec_stop_nxt;
      o_dsp_start <= dsp_start_nxt;
      o_dsp_pause <= dsp_pause_nxt;
      o_dsp_stop  <= dsp_stop_nxt;
      // On auto-stop i_rec_addr is already all-ones, so one load path serves both.
      if (len_load)
        o_rec_len <= i_rec_addr;
      if (cfg_load) begin
        o_speed                      <= speed_san;
        {o_fast, o_slow_0, o_slow_1} <= mode_oh;
      end
    end
  end

  logic in_rec;
  assign in_rec       = (state == ST_REC) || (state == ST_REC_PAUSE);
  assign o_sram_addr  = in_rec ? i_rec_addr : i_dsp_addr;
  assign o_sram_wdata = in_rec ? i_rec_data : 16'd0;
  assign o_sram_we_n  = ~((state == ST_REC) & i_rec_we);
  assign o_state      = state;

endmodule

// File: tb/tb_aud_ctrl_sched.sv
// tb/tb_aud_ctrl_sched.sv - self-checking bench for aud_ctrl_sched
module tb_aud_ctrl_sched;

  localparam int AW = 20;
  localparam logic [AW-1:0] ALL1 = {AW{1'b1}};

  logic          clk = 1'b0;
  logic          rst;
  logic          key_rec, key_play, key_pause, key_stop;
  logic [3:0]    cfg_speed;
  logic [1:0]    cfg_mode;
  logic [AW-1:0] rec_addr;
  logic [15:0]   rec_data;
  logic          rec_we;
  logic [AW-1:0] dsp_addr;
  logic          dsp_finished;
  logic          rec_start, rec_pause, rec_stop;
  logic          dsp_start, dsp_pause, dsp_stop;
  logic [3:0]    speed;
  logic          fast, slow_0, slow_1;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_wdata;
  logic          sram_we_n;
  logic [AW-1:0] rec_len;
  logic [2:0]    state;

  aud_ctrl_sched #(.ADDR_W(AW), .SPEED_MAX(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_key_rec(key_rec), .i_key_play(key_play),
    .i_key_pause(key_pause), .i_key_stop(key_stop),
    .i_cfg_speed(cfg_speed), .i_cfg_mode(cfg_mode),
    .i_rec_addr(rec_addr), .i_rec_data(rec_data), .i_rec_we(rec_we),
    .i_dsp_addr(dsp_addr), .i_dsp_finished(dsp_finished),
    .o_rec_start(rec_start), .o_rec_pause(rec_pause), .o_rec_stop(rec_stop),
    .o_dsp_start(dsp_start), .o_dsp_pause(dsp_pause), .o_dsp_stop(dsp_stop),
    .o_speed(speed), .o_fast(fast), .o_slow_0(slow_0), .o_slow_1(slow_1),
    .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata), .o_sram_we_n(sram_we_n),
    .o_rec_len(rec_len), .o_state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] pulses();
    return {rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst = 1'b0; key_rec = 1'b0; key_play = 1'b0; key_pause = 1'b0; key_stop = 1'b0;
    cfg_speed = 4'd0; cfg_mode = 2'd0; rec_addr = '0; rec_data = 16'd0;
    rec_we = 1'b0; dsp_addr = '0; dsp_finished = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Reference model: state names as small integers, speed/mode by the rules
  int            m_state;  // 0 idle,1 rec,2 rec_pause,3 play,4 play_pause
  logic [AW-1:0] m_len;
  int            m_speed;
  logic [2:0]    m_mode;   // {fast, slow_0, slow_1}
  logic [5:0]    m_pulse;

  task automatic m_latch();
    m_speed = (cfg_speed == 0) ? 1 : (cfg_speed > 8) ? 8 : int'(cfg_speed);
    m_mode  = (cfg_mode == 1) ? 3'b010 : (cfg_mode == 2) ? 3'b001 : 3'b100;
  endtask

  task automatic model_step();
    string key;
    m_pulse = 6'b0;
    if (rst) begin
      m_state = 0; m_len = '0; m_speed = 1; m_mode = 3'b100;
      return;
    end
    key = key_stop ? "stop" : key_pause ? "pause" : key_rec ? "rec" : key_play ? "play" : "none";
    if (m_state == 0) begin
      if (key == "rec") begin m_state = 1; m_pulse = 6'b100000; end
      else if (key == "play" && m_len != 0) begin m_state = 3; m_pulse = 6'b000100; m_latch(); end
    end else if (m_state == 1 || m_state == 2) begin
      if (key == "stop" || (m_state == 1 && rec_addr == ALL1)) begin
        m_state = 0; m_pulse = 6'b001000; m_len = rec_addr;
      end else if (key == "pause") begin
        m_state = (m_state == 1) ? 2 : 1; m_pulse = 6'b010000;
      end
    end else begin
      if (key == "stop" || (m_state == 3 && (dsp_finished || dsp_addr >= m_len))) begin
        m_state = 0; m_pulse = 6'b000001;
      end else if (key == "pause") begin
        if (m_state == 3) m_state = 4;
        else begin m_state = 3; m_latch(); end
        m_pulse = 6'b000010;
      end
    end
  endtask

  typedef struct {
    logic [3:0]    keys;   // {stop, pause, rec, play}
    logic [3:0]    spd;
    logic [1:0]    md;
    logic [AW-1:0] ra;
    logic          we;
    logic [AW-1:0] da;
    logic          fin;
    logic [2:0]    e_state;
    logic [5:0]    e_pulse;
    logic [3:0]    e_speed;
    logic [2:0]    e_mode;
    logic [AW-1:0] e_len;
    logic          e_we_n;
  } vec_t;

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{4'h1, 4'd0,  2'd0, 20'h0,     1'b0, 20'h0,   1'b0, 3'd0, 6'b000000, 4'd1, 3'b100, 20'h0,     1'b1};
    vecs[1]  = '{4'h2, 4'd0,  2'd0, 20'h10,    1'b1, 20'h0,   1'b0, 3'd1, 6'b100000, 4'd1, 3'b100, 20'h0,     1'b0};
    vecs[2]  = '{4'h0, 4'd0,  2'd0, 20'h20,    1'b1, 20'h0,   1'b0, 3'd1, 6'b000000, 4'd1, 3'b100, 20'h0,     1'b0};
    vecs[3]  = '{4'hC, 4'd0,  2'd0, 20'h123,   1'b1, 20'h0,   1'b0, 3'd0, 6'b001000, 4'd1, 3'b100, 20'h123,   1'b1};
    vecs[4]  = '{4'h1, 4'd12, 2'd3, 20'h0,     1'b0, 20'h0,   1'b0, 3'd3, 6'b000100, 4'd8, 3'b100, 20'h123,   1'b1};
    vecs[5]  = '{4'h4, 4'd12, 2'd3, 20'h0,     1'b0, 20'h0,   1'b0, 3'd4, 6'b000010, 4'd8, 3'b100, 20'h123,   1'b1};
    vecs[6]  = '{4'h0, 4'd0,  2'd2, 20'h0,     1'b0, 20'h0,   1'b0, 3'd4, 6'b000000, 4'd8, 3'b100, 20'h123,   1'b1};
    vecs[7]  = '{4'h4, 4'd0,  2'd2, 20'h0,     1'b0, 20'h0,   1'b0, 3'd3, 6'b000010, 4'd1, 3'b001, 20'h123,   1'b1};
    vecs[8]  = '{4'h0, 4'd0,  2'd2, 20'h0,     1'b0, 20'h122, 1'b0, 3'd3, 6'b000000, 4'd1, 3'b001, 20'h123,   1'b1};
    vecs[9]  = '{4'h0, 4'd0,  2'd2, 20'h0,     1'b0, 20'h123, 1'b0, 3'd0, 6'b000001, 4'd1, 3'b001, 20'h123,   1'b1};
    vecs[10] = '{4'h2, 4'd0,  2'd0, 20'h0,     1'b0, 20'h0,   1'b0, 3'd1, 6'b100000, 4'd1, 3'b001, 20'h123,   1'b1};
    vecs[11] = '{4'h4, 4'd0,  2'd0, 20'h5,     1'b1, 20'h0,   1'b0, 3'd2, 6'b010000, 4'd1, 3'b001, 20'h123,   1'b1};
    vecs[12] = '{4'h2, 4'd0,  2'd0, 20'h5,     1'b1, 20'h0,   1'b0, 3'd2, 6'b000000, 4'd1, 3'b001, 20'h123,   1'b1};
    vecs[13] = '{4'h4, 4'd0,  2'd0, 20'h6,     1'b1, 20'h0,   1'b0, 3'd1, 6'b010000, 4'd1, 3'b001, 20'h123,   1'b0};
    vecs[14] = '{4'h0, 4'd0,  2'd0, 20'hFFFFF, 1'b1, 20'h0,   1'b0, 3'd0, 6'b001000, 4'd1, 3'b001, 20'hFFFFF, 1'b1};
    vecs[15] = '{4'h1, 4'd5,  2'd1, 20'h0,     1'b0, 20'h0,   1'b0, 3'd3, 6'b000100, 4'd5, 3'b010, 20'hFFFFF, 1'b1};
    vecs[16] = '{4'h0, 4'd5,  2'd1, 20'h0,     1'b0, 20'h0,   1'b1, 3'd0, 6'b000001, 4'd5, 3'b010, 20'hFFFFF, 1'b1};
    vecs[17] = '{4'hA, 4'd5,  2'd1, 20'h0,     1'b0, 20'h0,   1'b0, 3'd0, 6'b000000, 4'd5, 3'b010, 20'hFFFFF, 1'b1};

    // Reset state
    do_reset();
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_pulses", 64'(pulses()), 64'd0);
    chk("reset_speed", 64'(speed), 64'd1);
    chk("reset_mode", 64'({fast, slow_0, slow_1}), 64'b100);
    chk("reset_len", 64'(rec_len), 64'd0);
    chk("reset_we_n", 64'(sram_we_n), 64'd1);

    // Table-driven sequence
    for (int i = 0; i < 18; i++) begin
      {key_stop, key_pause, key_rec, key_play} = vecs[i].keys;
      cfg_speed = vecs[i].spd; cfg_mode = vecs[i].md;
      rec_addr = vecs[i].ra; rec_we = vecs[i].we;
      dsp_addr = vecs[i].da; dsp_finished = vecs[i].fin;
      tick();
      chk($sformatf("vec%0d_state", i), 64'(state), 64'(vecs[i].e_state));
      chk($sformatf("vec%0d_pulse", i), 64'(pulses()), 64'(vecs[i].e_pulse));
      chk($sformatf("vec%0d_speed", i), 64'(speed), 64'(vecs[i].e_speed));
      chk($sformatf("vec%0d_mode", i), 64'({fast, slow_0, slow_1}), 64'(vecs[i].e_mode));
      chk($sformatf("vec%0d_len", i), 64'(rec_len), 64'(vecs[i].e_len));
      chk($sformatf("vec%0d_we_n", i), 64'(sram_we_n), 64'(vecs[i].e_we_n));
    end

    // Record from cycle 10 to cycle 50; write strobe only visible while recording
    do_reset();
    for (int cyc = 1; cyc <= 60; cyc++) begin
      key_rec  = (cyc == 10);
      key_stop = (cyc == 50);
      rec_addr = (cyc == 50) ? 20'h00123 : AW'(cyc);
      rec_we   = 1'($urandom);
      tick();
      chk($sformatf("rec_start_c%0d", cyc + 1), 64'(rec_start), 64'(cyc == 10));
      chk($sformatf("rec_stop_c%0d", cyc + 1), 64'(rec_stop), 64'(cyc == 50));
      chk($sformatf("we_n_c%0d", cyc + 1), 64'(sram_we_n), 64'(!(cyc >= 10 && cyc < 50 && rec_we)));
    end
    chk("rec_len_123", 64'(rec_len), 64'h123);
    chk("rec_state_idle", 64'(state), 64'd0);

    // Reset in the middle of playback, with a stop key pending
    clear_inputs();
    key_play = 1'b1; cfg_speed = 4'd7; cfg_mode = 2'd1;
    tick();
    clear_inputs();
    chk("midplay_state", 64'(state), 64'd3);
    chk("midplay_speed", 64'(speed), 64'd7);
    tick();
    rst = 1'b1; key_stop = 1'b1; rec_we = 1'b1;
    tick();
    chk("rst_play_state", 64'(state), 64'd0);
    chk("rst_play_pulses", 64'(pulses()), 64'd0);
    chk("rst_play_speed", 64'(speed), 64'd1);
    chk("rst_play_mode", 64'({fast, slow_0, slow_1}), 64'b100);
    chk("rst_play_we_n", 64'(sram_we_n), 64'd1);
    chk("rst_play_len", 64'(rec_len), 64'd0);

    // Randomised run against the reference model
    do_reset();
    m_state = 0; m_len = '0; m_speed = 1; m_mode = 3'b100;
    for (int n = 0; n < 4000; n++) begin
      rst          = ($urandom % 300) == 0;
      key_rec      = ($urandom % 8) == 0;
      key_play     = ($urandom % 6) == 0;
      key_pause    = ($urandom % 10) == 0;
      key_stop     = ($urandom % 25) == 0;
      cfg_speed    = 4'($urandom);
      cfg_mode     = 2'($urandom);
      rec_addr     = (($urandom % 40) == 0) ? ALL1 : AW'($urandom_range(0, 1023));
      rec_data     = 16'($urandom);
      rec_we       = 1'($urandom);
      dsp_addr     = (($urandom % 12) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
      dsp_finished = ($urandom % 64) == 0;
      model_step();
      tick();
      chk($sformatf("rnd%0d_state_pulse", n), 64'({state, pulses()}), 64'({3'(m_state), m_pulse}));
      chk($sformatf("rnd%0d_cfg", n), 64'({speed, fast, slow_0, slow_1}), 64'({4'(m_speed), m_mode}));
      chk($sformatf("rnd%0d_len", n), 64'(rec_len), 64'(m_len));
      chk($sformatf("rnd%0d_sram", n), 64'({sram_addr, sram_wdata, sram_we_n}),
          (m_state == 1 || m_state == 2) ? 64'({rec_addr, rec_data, !(m_state == 1 && rec_we)})
                                         : 64'({dsp_addr, 16'd0, 1'b1}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aud_ctrl_sched.md
Name: aud_ctrl_sched

Overview:
Top-level sequencer for the audio record/playback path. It converts debounced user key pulses into start/pause/stop command pulses for the recorder and the playback DSP. It latches and sanitises the playback speed and mode configuration, tracks the recorded length, and ends playback at that length. It also arbitrates the single SRAM port between the recorder (write) and the DSP (read).

Parameters:
ADDR_W, 20, SRAM word-address width
SPEED_MAX, 8, largest legal speed factor; larger requests clamp to this value

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_rst  in  1  synchronous active-high reset
i_key_rec  in  1  one-cycle pulse: record request
i_key_play  in  1  one-cycle pulse: play request
i_key_pause  in  1  one-cycle pulse: pause/resume toggle
i_key_stop  in  1  one-cycle pulse: stop
i_cfg_speed  in  4  requested speed factor
i_cfg_mode  in  2  0=fast, 1=slow constant interpolation, 2=slow linear interpolation, 3=illegal
i_rec_addr  in  ADDR_W  recorder's current write address
i_rec_data  in  16  recorder write data
i_rec_we  in  1  recorder write strobe
i_dsp_addr  in  ADDR_W  DSP's current read address
i_dsp_finished  in  1  DSP end-of-memory flag
o_rec_start, o_rec_pause, o_rec_stop  out  1 each  one-cycle command pulses to the recorder
o_dsp_start, o_dsp_pause, o_dsp_stop  out  1 each  one-cycle command pulses to the DSP
o_speed  out  4  latched, sanitised speed factor
o_fast, o_slow_0, o_slow_1  out  1 each  latched one-hot mode
o_sram_addr  out  ADDR_W  muxed SRAM address
o_sram_wdata  out  16  SRAM write data
o_sram_we_n  out  1  SRAM write enable, active low
o_rec_len  out  ADDR_W  length of the last completed recording
o_state  out  3  FSM state code for display

Behaviour:
- FSM states and codes: IDLE=0, REC=1, REC_PAUSE=2, PLAY=3, PLAY_PAUSE=4. All state is registered.
- Key priority when several keys are high in the same cycle: stop > pause > rec > play. Only the highest-priority key is acted on; the others are dropped.
- Transitions:
  - IDLE + rec -> REC; o_rec_start=1.
  - IDLE + play with o_rec_len != 0 -> PLAY; o_dsp_start=1. With o_rec_len == 0, play is ignored.
  - REC + pause -> REC_PAUSE; o_rec_pause=1.
  - REC_PAUSE + pause -> REC; o_rec_pause=1.
  - PLAY + pause -> PLAY_PAUSE; o_dsp_pause=1.
  - PLAY_PAUSE + pause -> PLAY; o_dsp_pause=1.
  - REC or REC_PAUSE + stop -> IDLE; o_rec_stop=1; o_rec_len <= i_rec_addr.
  - REC with i_rec_addr == all-ones -> IDLE; o_rec_stop=1; o_rec_len <= all-ones (auto-stop when memory is full).
  - PLAY or PLAY_PAUSE + stop -> IDLE; o_dsp_stop=1.
  - PLAY with i_dsp_finished=1, or i_dsp_addr >= o_rec_len -> IDLE; o_dsp_stop=1 (auto-end).
  - Any key not listed for the current state is ignored. rec/play in a non-IDLE state does nothing.
- Command pulses are registered: each is high exactly one cycle, the cycle after the triggering key or condition. This is the same edge on which o_state updates.
- Config latch: i_cfg_speed and i_cfg_mode are captured on entry to PLAY, both from IDLE and on resume from PLAY_PAUSE. They are held constant otherwise.
  - Speed rule: value 0 -> 1; value > SPEED_MAX -> SPEED_MAX; otherwise unchanged.
  - Mode rule: code 3 -> fast mode. Exactly one of o_fast/o_slow_0/o_slow_1 is high at all times.
- SRAM arbitration is combinational from the registered state.
  - In REC or REC_PAUSE: o_sram_addr=i_rec_addr, o_sram_wdata=i_rec_data, o_sram_we_n = ~(state==REC & i_rec_we).
  - In all other states: o_sram_addr=i_dsp_addr, o_sram_wdata=0, o_sram_we_n=1.
  - A write is never issued outside REC.
- Reset (any cycle, including mid-record or mid-play):
  - state=IDLE; all command pulses 0; o_speed=1; o_fast=1, o_slow_0=0, o_slow_1=0; o_rec_len=0; o_sram_we_n=1.
  - No stop pulse is emitted on reset.
- Stop in the same cycle as an auto-end condition: a single stop pulse, not two. o_rec_len takes i_rec_addr.

Test Plan:
- Reset, then rec at cycle 10, stop at cycle 50 with i_rec_addr=0x00123 -> o_rec_start high at cycle 11 only; o_rec_stop high at cycle 51; o_rec_len=0x00123; o_state=0; o_sram_we_n follows ~i_rec_we only between cycles 11 and 50.
- o_rec_len=0x00100, i_cfg_speed=12, i_cfg_mode=3, play pulse -> o_dsp_start pulses once; o_speed=8; o_fast=1. When i_dsp_addr reaches 0x00100 -> o_dsp_stop pulses once; state IDLE.
- In PLAY: pause -> o_state=4. Set i_cfg_speed=0, i_cfg_mode=2, then pause again -> o_state=3; o_speed=1; o_slow_1=1; two o_dsp_pause pulses in total.
- Play pulse with o_rec_len=0 -> no o_dsp_start; o_state stays 0.
- Stop and pause keys high in the same cycle during REC -> only o_rec_stop pulses; state IDLE.
- Assert i_rst mid-PLAY -> next cycle o_state=0, o_speed=1, no stop pulse, o_sram_we_n=1.
